// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the RV32 subset datapath sharing one memory port.
// Build option: define ILLEGAL_TRAP_EN to make an illegal opcode a terminal trap state.
module multicycle_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ULAControl,
    output logic [1:0] ResultSrc,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB,
        S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BEQ, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_AND = 3'b010;
    localparam logic [2:0] ULA_OR  = 3'b011;
    localparam logic [2:0] ULA_XOR = 3'b100;
    localparam logic [2:0] ULA_SLT = 3'b101;
    localparam logic [2:0] ULA_SRL = 3'b111;

    state_t     state_q, state_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_write_q, mem_write_d;
    logic       adr_src_q, adr_src_d;
    logic       reg_write_q, reg_write_d;
    logic [1:0] imm_src_q, imm_src_d;
    logic [1:0] alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [2:0] ula_control_q, ula_control_d;
    logic [1:0] result_src_q, result_src_d;
    logic       illegal_d;
    logic [2:0] r_ula;
    logic [2:0] i_ula;

    always_comb begin
        r_ula = ULA_ADD;
        case ({Funct7, Funct3})
            10'b0000000_000: r_ula = ULA_ADD;
            10'b0100000_000: r_ula = ULA_SUB;
            10'b0000000_111: r_ula = ULA_AND;
            10'b0000000_110: r_ula = ULA_OR;
            10'b0000000_010: r_ula = ULA_SLT;
            10'b0000000_100: r_ula = ULA_XOR;
            10'b0000000_101: r_ula = ULA_SRL;
            default:         r_ula = ULA_ADD;
        endcase
    end

    always_comb begin
        i_ula = ULA_ADD;
        case (Funct3)
            3'b111:  i_ula = ULA_AND;
            3'b110:  i_ula = ULA_OR;
            default: i_ula = ULA_ADD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_ALUWB, S_MEMWB: state_d = S_FETCH;
            S_MEMADR:   state_d = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWRITE: if (MemReady) state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL:  state_d = S_ILLEGAL;
`else
            S_ILLEGAL:  state_d = S_FETCH;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        mem_req_d     = 1'b0;
        mem_write_d   = 1'b0;
        adr_src_d     = 1'b0;
        reg_write_d   = 1'b0;
        imm_src_d     = 2'b00;
        alu_src_a_d   = 2'b00;
        alu_src_b_d   = 2'b00;
        ula_control_d = ULA_ADD;
        result_src_d  = 2'b00;
        illegal_d     = 1'b0;
        case (state_d)
            S_FETCH: begin
                mem_req_d    = 1'b1;
                alu_src_b_d  = 2'b10;
                result_src_d = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b01;
                imm_src_d   = 2'b10;
            end
            S_EXECR: begin
                alu_src_a_d   = 2'b10;
                ula_control_d = r_ula;
            end
            S_EXECI: begin
                alu_src_a_d   = 2'b10;
                alu_src_b_d   = 2'b01;
                ula_control_d = i_ula;
            end
            S_ALUWB: reg_write_d = 1'b1;
            S_MEMADR: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b01;
                imm_src_d   = (Op == OP_STORE) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                mem_req_d = 1'b1;
                adr_src_d = 1'b1;
            end
            S_MEMWB: begin
                result_src_d = 2'b01;
                reg_write_d  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_d   = 1'b1;
                mem_write_d = 1'b1;
                adr_src_d   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_d   = 2'b10;
                ula_control_d = ULA_SUB;
            end
            S_ILLEGAL: illegal_d = 1'b1;
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mem_req_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            adr_src_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            imm_src_q     <= 2'b00;
            alu_src_a_q   <= 2'b00;
            alu_src_b_q   <= 2'b00;
            ula_control_q <= 3'b000;
            result_src_q  <= 2'b00;
`ifdef ILLEGAL_TRAP_EN
            illegal_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_write_q   <= mem_write_d;
            adr_src_q     <= adr_src_d;
            reg_write_q   <= reg_write_d;
            imm_src_q     <= imm_src_d;
            alu_src_a_q   <= alu_src_a_d;
            alu_src_b_q   <= alu_src_b_d;
            ula_control_q <= ula_control_d;
            result_src_q  <= result_src_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q     <= illegal_d;
`endif
        end
    end

    // Enables that depend on the handshake or on Zero are qualified in the same cycle.
    assign IRWrite    = (state_q == S_FETCH) && MemReady;
    assign PCWrite    = ((state_q == S_FETCH) && MemReady) || ((state_q == S_BEQ) && Zero);
    assign MemReq     = mem_req_q;
    assign MemWrite   = mem_write_q;
    assign AdrSrc     = adr_src_q;
    assign RegWrite   = reg_write_q;
    assign ImmSrc     = imm_src_q;
    assign ALUSrcA    = alu_src_a_q;
    assign ALUSrcB    = alu_src_b_q;
    assign ULAControl = ula_control_q;
    assign ResultSrc  = result_src_q;
`ifdef ILLEGAL_TRAP_EN
    assign Illegal    = illegal_q;
`else
    assign Illegal    = 1'b0;
    logic unused_illegal;
    assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: builds an expected per-cycle trace from the instruction-level rules,
// drives it into multicycle_sequencer and compares every cycle plus pinned counts.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] Op = '0;
    logic [2:0] Funct3 = '0;
    logic [6:0] Funct7 = '0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ULAControl;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct3(Funct3), .Funct7(Funct7),
        .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ULAControl(ULAControl),
        .ResultSrc(ResultSrc), .Illegal(Illegal)
    );

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BEQ = 7'b1100011, OP_BAD = 7'b1111111;

    localparam logic [7:0] T_RST = 8'd0, T_IDLE = 8'd1, T_FETCH = 8'd2, T_DEC = 8'd3;
    localparam logic [7:0] T_EXEC = 8'd4, T_WB = 8'd5, T_MADR = 8'd6, T_MEM = 8'd7;
    localparam logic [7:0] T_BEQ = 8'd8, T_ILL = 8'd9;

    localparam logic [3:0] L_RW = 4'd1, L_REQ = 4'd2, L_IRW = 4'd3, L_PCW = 4'd4;
    localparam logic [3:0] L_CYC = 4'd5, L_RWCYC = 4'd6, L_WR = 4'd7, L_ILL = 4'd8;

    typedef struct packed {
        logic            rst_n;
        logic            rdy;
        logic            zero;
        logic [6:0]      op;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [17:0]     exp;
        logic            mark;
        logic [3:0][3:0] lit;
        logic [3:0][7:0] lit_val;
        logic [7:0]      tag;
    } rec_t;

    rec_t       q[$];
    rec_t       cur;
    bit         cur_valid = 1'b0;
    logic [6:0] g_op;
    logic [2:0] g_f3;
    logic [6:0] g_f7;
    logic       g_zero;
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic string tag_name(input logic [7:0] t);
        case (t)
            T_RST:   return "reset";
            T_IDLE:  return "idle";
            T_FETCH: return "fetch";
            T_DEC:   return "decode";
            T_EXEC:  return "execute";
            T_WB:    return "writeback";
            T_MADR:  return "memadr";
            T_MEM:   return "memaccess";
            T_BEQ:   return "beq";
            default: return "illegal";
        endcase
    endfunction

    function automatic string lit_name(input logic [3:0] c);
        case (c)
            L_RW:    return "regwrite_count";
            L_REQ:   return "memreq_count";
            L_IRW:   return "irwrite_count";
            L_PCW:   return "pcwrite_count";
            L_CYC:   return "instr_cycles";
            L_RWCYC: return "regwrite_cycle";
            L_WR:    return "memwrite_count";
            default: return "illegal_count";
        endcase
    endfunction

    // Expected output vector, fields in the order the compare process packs the DUT.
    function automatic logic [17:0] ov(input logic req, wr, adr, irw, pcw, rw,
                                       input logic [1:0] imm, a, b,
                                       input logic [2:0] ula,
                                       input logic [1:0] res,
                                       input logic ill);
        return {req, wr, adr, irw, pcw, rw, imm, a, b, ula, res, ill};
    endfunction

    function automatic logic [2:0] alu_r(input logic [6:0] f7, input logic [2:0] f3);
        logic [9:0] k;
        k = {f7, f3};
        case (k)
            10'b0100000_000: return 3'b001;
            10'b0000000_111: return 3'b010;
            10'b0000000_110: return 3'b011;
            10'b0000000_100: return 3'b100;
            10'b0000000_010: return 3'b101;
            10'b0000000_101: return 3'b111;
            default:         return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_i(input logic [2:0] f3);
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b110) return 3'b011;
        return 3'b000;
    endfunction

    task automatic push(input logic rdy, input logic [17:0] e, input logic [7:0] tag);
        rec_t r;
        r = '0;
        r.rst_n = 1'b1; r.rdy = rdy; r.zero = g_zero;
        r.op = g_op; r.f3 = g_f3; r.f7 = g_f7; r.exp = e; r.tag = tag;
        q.push_back(r);
    endtask

    task automatic reset_seq(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            push(1'b1, 18'd0, T_RST);
            r = q[q.size()-1];
            r.rst_n = 1'b0;
            q[q.size()-1] = r;
        end
        push(1'b1, 18'd0, T_IDLE);
    endtask

    task automatic add_lit(input logic [3:0] code, input int val);
        rec_t r;
        bit   done;
        r = q[q.size()-1];
        done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!done && r.lit[k] == 4'd0) begin
                r.lit[k] = code;
                r.lit_val[k] = 8'(val);
                done = 1'b1;
            end
        end
        q[q.size()-1] = r;
    endtask

    task automatic mark_at(input int idx);
        rec_t r;
        r = q[idx];
        r.mark = 1'b1;
        q[idx] = r;
    endtask

    task automatic fetch_decode(input int fwait, input logic ordy);
        for (int i = 0; i < fwait; i++)
            push(1'b0, ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0), T_FETCH);
        push(1'b1, ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 3'd0, 2'd2, 1'b0), T_FETCH);
        push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd1, 3'd0, 2'd0, 1'b0), T_DEC);
    endtask

    // Expands one instruction into its expected cycle trace (fwait/mwait = wait states).
    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic zero, input int fwait, input int mwait, input logic ordy);
        int start;
        g_op = op; g_f3 = f3; g_f7 = f7; g_zero = zero;
        start = q.size();
        fetch_decode(fwait, ordy);
        case (op)
            OP_R: begin
                push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, alu_r(f7, f3), 2'd0, 1'b0), T_EXEC);
                push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0), T_WB);
            end
            OP_I: begin
                push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, alu_i(f3), 2'd0, 1'b0), T_EXEC);
                push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0), T_WB);
            end
            OP_LD: begin
                push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0), T_MADR);
                for (int i = 0; i <= mwait; i++)
                    push(i == mwait, ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0), T_MEM);
                push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd1, 1'b0), T_WB);
            end
            OP_ST: begin
                push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0), T_MADR);
                for (int i = 0; i <= mwait; i++)
                    push(i == mwait, ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0), T_MEM);
            end
            OP_BEQ:
                push(ordy, ov(1'b0, 1'b0, 1'b0, 1'b0, zero, 1'b0, 2'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1'b0), T_BEQ);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 20; i++)
                    push(1'b1, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1), T_ILL);
`else
                push(ordy, 18'd0, T_ILL);
`endif
            end
        endcase
        mark_at(start);
    endtask

    // Compare process: DUT outputs against the expected trace, once per cycle.
    initial begin : compare
        logic [17:0] act;
        int          cnt[9];
        int          snap[9];
        int          cyc, last_rw, tot, a;
        logic [3:0]  code;
        cyc = 0; last_rw = 0; tot = 0;
        for (int i = 0; i < 9; i++) begin cnt[i] = 0; snap[i] = 0; end
        forever begin
            @(negedge clk);
            if (cur_valid) begin
                tot++;
                act = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ImmSrc, ALUSrcA, ALUSrcB, ULAControl, ResultSrc, Illegal};
                if (cur.mark) for (int i = 0; i < 9; i++) snap[i] = cnt[i];
                cnt[L_RW]  += (RegWrite === 1'b1) ? 1 : 0;
                cnt[L_REQ] += (MemReq === 1'b1) ? 1 : 0;
                cnt[L_IRW] += (IRWrite === 1'b1) ? 1 : 0;
                cnt[L_PCW] += (PCWrite === 1'b1) ? 1 : 0;
                cnt[L_CYC] += 1;
                cnt[L_WR]  += (MemWrite === 1'b1) ? 1 : 0;
                cnt[L_ILL] += (Illegal === 1'b1) ? 1 : 0;
                if (!cur.rst_n) cyc = 0; else cyc++;
                if (RegWrite === 1'b1) last_rw = cyc;
                n_cmp++;
                if (act !== cur.exp) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: outputs got %05h expected %05h", tag_name(cur.tag), tot, act, cur.exp);
                end
                for (int k = 0; k < 4; k++) begin
                    code = cur.lit[k];
                    if (code != 4'd0) begin
                        a = (code == L_RWCYC) ? last_rw : cnt[code] - snap[code];
                        n_cmp++;
                        if (a != int'(cur.lit_val[k])) begin
                            n_bad++;
                            $display("FAIL %s at cycle %0d: got %0d expected %0d", lit_name(code), tot, a, cur.lit_val[k]);
                        end
                    end
                end
            end
        end
    end

    initial begin : driver
        int start;
        g_op = OP_I; g_f3 = 3'b000; g_f7 = 7'b0000000; g_zero = 1'b0;

        // Reset release straight into addi x1,x0,5 with MemReady high.
        reset_seq(2);
        mark_at(q.size()-1);
        instr(OP_I, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1);
        add_lit(L_RW, 1); add_lit(L_RWCYC, 5); add_lit(L_CYC, 4);

        // sub with three fetch wait states; Zero held high to catch stray PCWrite.
        instr(OP_R, 3'b000, 7'b0100000, 1'b1, 3, 0, 1'b0);
        add_lit(L_REQ, 4); add_lit(L_IRW, 1); add_lit(L_PCW, 1); add_lit(L_CYC, 7);

        // Remaining R-type and I-type operation decodes, including unlisted codes.
        instr(OP_R, 3'b111, 7'b0000000, 1'b0, 0, 0, 1'b1);
        instr(OP_R, 3'b110, 7'b0000000, 1'b0, 0, 0, 1'b0);
        instr(OP_R, 3'b100, 7'b0000000, 1'b0, 0, 0, 1'b1);
        instr(OP_R, 3'b010, 7'b0000000, 1'b0, 0, 0, 1'b1);
        instr(OP_R, 3'b101, 7'b0000000, 1'b0, 0, 0, 1'b1);
        instr(OP_R, 3'b101, 7'b0100000, 1'b0, 0, 0, 1'b1);
        instr(OP_R, 3'b000, 7'b0000000, 1'b1, 0, 0, 1'b1);
        instr(OP_I, 3'b111, 7'b0000000, 1'b0, 0, 0, 1'b1);
        instr(OP_I, 3'b110, 7'b0000000, 1'b0, 0, 0, 1'b0);
        instr(OP_I, 3'b100, 7'b0000000, 1'b0, 0, 0, 1'b1);

        // lb then sb with no waits, then with memory wait states.
        instr(OP_LD, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1);
        add_lit(L_CYC, 5); add_lit(L_RW, 1); add_lit(L_WR, 0);
        instr(OP_ST, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1);
        add_lit(L_CYC, 4); add_lit(L_WR, 1); add_lit(L_RW, 0);
        instr(OP_LD, 3'b000, 7'b0000000, 1'b1, 0, 2, 1'b0);
        add_lit(L_CYC, 7); add_lit(L_REQ, 4);
        instr(OP_ST, 3'b000, 7'b0000000, 1'b0, 1, 1, 1'b1);
        add_lit(L_CYC, 6); add_lit(L_WR, 2);

        // beq taken, then not taken.
        instr(OP_BEQ, 3'b000, 7'b0000000, 1'b1, 0, 0, 1'b1);
        add_lit(L_CYC, 3); add_lit(L_PCW, 2);
        instr(OP_BEQ, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1);
        add_lit(L_CYC, 3); add_lit(L_PCW, 1);

        // sb aborted by reset while waiting in the write access.
        g_op = OP_ST; g_f3 = 3'b000; g_f7 = 7'b0000000; g_zero = 1'b1;
        start = q.size();
        fetch_decode(0, 1'b1);
        push(1'b1, ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 3'd0, 2'd0, 1'b0), T_MADR);
        push(1'b0, ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0), T_MEM);
        push(1'b0, ov(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0), T_MEM);
        reset_seq(2);
        mark_at(start);
        add_lit(L_RW, 0); add_lit(L_WR, 2); add_lit(L_PCW, 1); add_lit(L_CYC, 8);
        instr(OP_I, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1);

        // Illegal opcode.
        instr(OP_BAD, 3'b000, 7'b0000000, 1'b0, 0, 0, 1'b1);
`ifdef ILLEGAL_TRAP_EN
        add_lit(L_ILL, 20); add_lit(L_REQ, 1); add_lit(L_CYC, 22);
        reset_seq(1);
`else
        add_lit(L_ILL, 0); add_lit(L_CYC, 3);
`endif
        instr(OP_I, 3'b110, 7'b0000000, 1'b0, 0, 0, 1'b1);
        add_lit(L_CYC, 4);

        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            cur = q.pop_front();
            rst_n    = cur.rst_n;
            MemReady = cur.rdy;
            Zero     = cur.zero;
            Op       = cur.op;
            Funct3   = cur.f3;
            Funct7   = cur.f7;
            cur_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        cur_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control sequencer for the RV32 subset datapath (R-type ALU ops, addi/andi/ori, lb, sb, beq). It replaces single-cycle control when instruction fetch and data access share one memory port. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives datapath mux selects, register/PC/IR enables and a request/ready memory handshake. ULA operation encoding matches the existing control decoder.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Op  in  7  instruction opcode from IR.
- Funct3  in  3  IR[14:12].
- Funct7  in  7  IR[31:25].
- Zero  in  1  ULA zero flag, combinational from current ULA result.
- MemReady  in  1  memory completes the current request this cycle.
- MemReq  out  1  memory access request.
- MemWrite  out  1  request is a write; valid only with MemReq.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  write rd.
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 register.
- ALUSrcB  out  2  00 rs2 register, 01 immediate, 10 constant 4.
- ULAControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 111 srl.
- ResultSrc  out  2  00 ALUOut, 01 memory data register, 10 ULA result direct.
- Illegal  out  1  illegal-opcode flag (see Configuration).

## Operation
- Moore FSM. All outputs decode from the state register only, except PCWrite in BEQ (Zero) and handshake-qualified enables. Every output not listed for a state is 0.
- IDLE: reset state; all outputs 0. Goes to FETCH unconditionally.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ULAControl=000, ResultSrc=10. On MemReady: IRWrite=1, PCWrite=1, then go to DECODE. Otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ULAControl=000 (branch target into ALUOut). Next state by Op:
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0000011 / 0100011 → MEMADR
  - 1100011 → BEQ
  - other → ILLEGAL
- EXECR: ALUSrcA=10, ALUSrcB=00; ULAControl from {Funct7,Funct3}:
  - 0000000_000 add, 0100000_000 sub, 0000000_111 and, 0000000_110 or, 0000000_010 slt, 0000000_100 xor, 0000000_101 srl
  - any other combination → 000
  - Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00; Funct3 000 add, 111 and, 110 or, other → 000. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ULAControl=000; ImmSrc=00 for load, 01 for store. Next: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: MemReq=1, AdrSrc=1. On MemReady go to MEMWB, else hold.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. On MemReady go to FETCH, else hold.
- BEQ: ALUSrcA=10, ALUSrcB=00, ULAControl=001, ResultSrc=00, PCWrite=Zero. Next: FETCH.
- ILLEGAL: behaviour set by Configuration.

## Timing
- Reset: asynchronous entry to IDLE. All outputs 0 while rst_n=0 and during the first cycle after release. First FETCH is in the second cycle.
- Instruction latency in cycles, zero wait states: R/I 4, lb 5, sb 4, beq 3. Each wait cycle adds one.
- Handshake:
  - MemReq and its address/write selects stay stable until the cycle MemReady=1 is sampled.
  - MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
  - IRWrite and PCWrite in FETCH pulse exactly one cycle, the MemReady cycle.
- MemReady held high continuously gives back-to-back accesses with no idle cycle inside FETCH.
- rst_n asserted mid-handshake drops MemReq in the same cycle, asynchronously. No write enable is issued afterwards.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - ILLEGAL is terminal. Illegal=1 and all other outputs 0 until reset.
  - MemReq is never reasserted.
- ILLEGAL_TRAP_EN undefined:
  - ILLEGAL acts as a NOP and goes to FETCH next cycle. The PC was already advanced by 4.
  - Illegal is tied to 0.

## Test plan
- Reset release with MemReady=1, IR=0x00500093 (addi x1,x0,5) → states IDLE, FETCH, DECODE, EXECI, ALUWB. RegWrite=1 only in cycle 5, with ALUSrcB=01 in EXECI.
- R-type sub (Funct7=0100000, Funct3=000) with MemReady low 3 cycles in FETCH → MemReq held 4 cycles. IRWrite/PCWrite pulse once. ULAControl=001 in EXECR.
- lb then sb, MemReady=1 → lb takes 5 cycles with AdrSrc=1 in MEMREAD and ResultSrc=01 in MEMWB. sb takes 4 cycles with MemWrite=1 only in MEMWRITE and ImmSrc=01 in MEMADR.
- beq with Zero=1, then Zero=0 → PCWrite=1 in BEQ for taken, 0 for not-taken. ULAControl=001. Each completes in 3 cycles.
- rst_n pulsed low during MEMWRITE wait → MemReq and MemWrite drop immediately, FSM restarts at IDLE, and no RegWrite or PCWrite is seen.
- Op=1111111 → with ILLEGAL_TRAP_EN: Illegal=1 stays high and MemReq stays 0 for 20 cycles. Without it: FETCH is re-entered on the cycle after ILLEGAL, and Illegal stays 0.
